digit_frame_ctrl: RTL and testbench
===================================

# digit_frame_ctrl

Controller between the PicoBlaze output port and the four-digit display path. It takes ASCII characters written by the processor, converts them to nibbles, and stages them in a shadow frame. A commit command makes all four digits change on the same cycle. It also time-multiplexes the committed frame onto the shared seven-segment digit bus, with a staging timeout so a half-written frame never sticks.

## Interface
- SCAN_DIV, default 50000: clk cycles per scan slot (≥2).
- TIMEOUT, default 1000000: cycles allowed in STAGING before the frame is abandoned (≥2).
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  one-cycle write strobe from the processor port.
- select  in  3  target: 0–3 = digit0–digit3 shadow, 4 = commit, 5–7 ignored.
- data  in  8  ASCII character, used only when select 0–3.
- digit0..digit3  out  4 each  committed nibbles.
- blank  out  4  committed blank flags, bit i for digit i.
- scan_nibble  out  4  nibble of the digit currently scanned.
- an  out  4  digit enables, active-low, one-hot or all-high.
- busy  out  1  high in STAGING.
- err_char  out  1  one-cycle pulse on an invalid character.
- err_timeout  out  1  one-cycle pulse when a frame is abandoned.

## Operation
- Conversion rules:
  - '0'–'9' (0x30–0x39) → data−0x30, blank=0.
  - 'A'–'F' (0x41–0x46) → data−0x37, blank=0.
  - space (0x20) → nibble 0, blank=1.
  - Any other value: shadow unchanged, err_char pulses; the state still moves to STAGING if it was IDLE.
- FSM states: IDLE, STAGING, COMMIT.
  - IDLE: shadow equals committed. A wr_en with select 0–3 writes the shadow and goes to STAGING. A wr_en with select=4 goes to COMMIT (a harmless recommit).
  - STAGING: shadow writes continue. select=4 → COMMIT. Timeout counter reaches TIMEOUT−1 → shadow reloaded from committed, err_timeout pulses, → IDLE.
  - COMMIT: lasts one cycle. Committed ← shadow (all nibbles and blank flags together), then → IDLE. A wr_en arriving in COMMIT is applied after the copy: shadow writes go to the shadow and the FSM → STAGING; select=4 → COMMIT again.
- Timeout counter:
  - Clears on entry to STAGING and on every shadow write.
  - Saturates; never wraps.
- select 5–7: no effect on shadow, state or errors.
- Scan:
  - Free-running slot counter 0..SCAN_DIV−1, which wraps.
  - Slot index 0→1→2→3→0 advances on each wrap.
  - an = ~(1<<index), forced to 4'b1111 when blank[index].
  - scan_nibble = committed digit[index].
  - Scan is independent of the FSM; a commit mid-slot takes effect on the next cycle.

## Timing
- Reset values:
  - digit0=1, digit1=2, digit2=3, digit3=4 in both shadow and committed.
  - blank=0; state IDLE; busy=0; err_char=0; err_timeout=0.
  - Slot counter 0, index 0, an=4'b1110, scan_nibble=1.
- Shadow write: wr_en at edge N → shadow updated at N; not visible on the outputs.
- Commit latency: select=4 sampled at edge N → COMMIT during N..N+1 → digits/blank updated at edge N+1, i.e. visible 2 cycles after the strobe cycle begins.
- Error pulses: err_char is asserted the cycle after the offending strobe; err_timeout on the cycle the FSM returns to IDLE.
- busy is registered and equals (state==STAGING).
- Reset mid-frame: shadow is discarded, committed returns to reset values, and no error pulse is produced.

## Structure
- Shared package digit_pkg holds:
  - the state enum;
  - select codes SEL_COMMIT=4 and digit selects 0–3;
  - ASCII constants for '0', 'A' and space;
  - reset digit values 1, 2, 3, 4.
- One sub-module is natural: ascii_to_nibble, a pure combinational conversion producing {valid, blank, nibble}.
- The scan logic stays inline.

## Test plan
- Reset, then no writes: digits=1,2,3,4, an cycles 1110→1101→1011→0111 every SCAN_DIV cycles, scan_nibble=1,2,3,4.
- Write "9","7","5","3" to selects 0–3, no commit: digits stay 1,2,3,4, busy=1. Then select=4: two cycles later digits=9,7,5,3, busy=0.
- Write 'B' to digit1, then 0x47 ('G') to digit2, then commit: digit1=0xB, digit2 unchanged, exactly one err_char pulse.
- Write ' ' to digit3 and commit: blank=4'b1000, an=4'b1111 during slot 3.
- Write to digit0 then idle for TIMEOUT cycles (small TIMEOUT in the bench): err_timeout pulses once, state IDLE; a following commit leaves digits at 1,2,3,4.
- Assert reset while in STAGING with a staged digit: all outputs return to reset values next cycle and no error pulses occur.

Source files
------------

// File: rtl/digit_pkg.sv
// Shared types and constants for the four-digit display frame controller.
package digit_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_STAGING, ST_COMMIT} state_t;

  localparam int NUM_DIGITS = 4;

  localparam logic [2:0] SEL_DIG0   = 3'd0;
  localparam logic [2:0] SEL_DIG1   = 3'd1;
  localparam logic [2:0] SEL_DIG2   = 3'd2;
  localparam logic [2:0] SEL_DIG3   = 3'd3;
  localparam logic [2:0] SEL_COMMIT = 3'd4;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  localparam logic [NUM_DIGITS-1:0][3:0] RST_DIGITS = {4'd4, 4'd3, 4'd2, 4'd1};

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] nibble;
  } conv_t;
endpackage

// File: rtl/ascii_to_nibble.sv
// Combinational ASCII hex/space to {valid, blank, nibble} conversion.
module ascii_to_nibble
  import digit_pkg::*;
(
  input  logic [7:0] data,
  output conv_t      conv
);
  always_comb begin
    conv = '0;
    if (data >= ASCII_ZERO && data <= ASCII_ZERO + 8'd9) begin
      conv.valid  = 1'b1;
      conv.nibble = data[3:0];
    end else if (data >= ASCII_A && data <= ASCII_A + 8'd5) begin
      // 'A' has low nibble 1, so +9 lands on 0xA
      conv.valid  = 1'b1;
      conv.nibble = data[3:0] + 4'd9;
    end else if (data == ASCII_SPACE) begin
      conv.valid = 1'b1;
      conv.blank = 1'b1;
    end
  end
endmodule

// File: rtl/digit_frame_ctrl.sv
// Shadow/committed four-digit frame with atomic commit, staging timeout and
// time-multiplexed scan onto a shared seven-segment digit bus.
module digit_frame_ctrl
  import digit_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int TIMEOUT  = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] select,
  input  logic [7:0] data,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] blank,
  output logic [3:0] scan_nibble,
  output logic [3:0] an,
  output logic       busy,
  output logic       err_char,
  output logic       err_timeout
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SCAN_DIV - 1);

  state_t                           state;
  logic [NUM_DIGITS-1:0][3:0]       shadow, commit_dig;
  logic [NUM_DIGITS-1:0]            shadow_blk, commit_blk;
  logic [TW-1:0]                    tmo_cnt;
  conv_t                            conv;
  logic                             dig_wr, cmt_wr;

  ascii_to_nibble u_conv (.data(data), .conv(conv));

  assign dig_wr = wr_en && (select <= SEL_DIG3);
  assign cmt_wr = wr_en && (select == SEL_COMMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      err_char    <= 1'b0;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
      shadow      <= RST_DIGITS;
      shadow_blk  <= '0;
      commit_dig  <= RST_DIGITS;
      commit_blk  <= '0;
    end else begin
      err_char    <= dig_wr && !conv.valid;
      err_timeout <= 1'b0;
      if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 1'b1;
      if (dig_wr) tmo_cnt <= '0;
      if (dig_wr && conv.valid) begin
        shadow[select[1:0]]     <= conv.nibble;
        shadow_blk[select[1:0]] <= conv.blank;
      end
      case (state)
        ST_IDLE: begin
          if (dig_wr) begin
            state <= ST_STAGING; busy <= 1'b1;
          end else if (cmt_wr) begin
            state <= ST_COMMIT;  busy <= 1'b0;
          end
        end
        ST_STAGING: begin
          if (cmt_wr) begin
            state <= ST_COMMIT; busy <= 1'b0;
          end else if (!dig_wr && tmo_cnt == TMO_MAX) begin
            // abandon the half-built frame
            state       <= ST_IDLE;
            busy        <= 1'b0;
            shadow      <= commit_dig;
            shadow_blk  <= commit_blk;
            err_timeout <= 1'b1;
          end
        end
        ST_COMMIT: begin
          // copy reads the pre-edge shadow, so a same-cycle write lands after it
          commit_dig <= shadow;
          commit_blk <= shadow_blk;
          if (dig_wr) begin
            state <= ST_STAGING; busy <= 1'b1;
          end else if (cmt_wr) begin
            state <= ST_COMMIT;  busy <= 1'b0;
          end else begin
            state <= ST_IDLE;    busy <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE; busy <= 1'b0;
        end
      endcase
    end
  end

  logic [SW-1:0] slot_cnt;
  logic [1:0]    scan_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt <= '0;
      scan_idx <= '0;
    end else if (slot_cnt == SLOT_MAX) begin
      slot_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign digit0      = commit_dig[0];
  assign digit1      = commit_dig[1];
  assign digit2      = commit_dig[2];
  assign digit3      = commit_dig[3];
  assign blank       = commit_blk;
  assign scan_nibble = commit_dig[scan_idx];
  assign an          = commit_blk[scan_idx] ? 4'b1111 : ~(4'b0001 << scan_idx);
endmodule

// File: tb/tb_digit_frame_ctrl.sv
// Directed + randomized bench for digit_frame_ctrl against a frame-level model.
module tb_digit_frame_ctrl;
  localparam int SCAN_DIV = 8;
  localparam int TIMEOUT  = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1, wr_en = 1'b0;
  logic [2:0] select = '0;
  logic [7:0] data = '0;
  logic [3:0] digit0, digit1, digit2, digit3, blank, scan_nibble, an;
  logic       busy, err_char, err_timeout;

  digit_frame_ctrl #(.SCAN_DIV(SCAN_DIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .select(select), .data(data),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .blank(blank), .scan_nibble(scan_nibble), .an(an), .busy(busy),
    .err_char(err_char), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int tmo_pulses = 0, char_pulses = 0;

  // model: frame contents, plus "a frame is being staged" / "commit pending"
  logic [3:0] m_shad[4], m_com[4];
  logic [3:0] m_shb, m_cob;
  bit         m_staged, m_pend, m_echar, m_etmo;
  int         m_quiet, m_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_conv(input logic [7:0] d, output logic [3:0] nib, output logic blk);
    int v;
    nib = 4'd0; blk = 1'b0;
    if (d >= 8'h30 && d <= 8'h39) begin
      v = int'(d) - 48; nib = v[3:0];
    end else if (d >= 8'h41 && d <= 8'h46) begin
      v = int'(d) - 65 + 10; nib = v[3:0];
    end else if (d == 8'h20) blk = 1'b1;
    else return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shad[i] = 4'(i + 1); m_com[i] = 4'(i + 1);
    end
    m_shb = '0; m_cob = '0;
    m_staged = 0; m_pend = 0; m_echar = 0; m_etmo = 0;
    m_quiet = 0; m_cyc = 0;
  endtask

  task automatic model_edge(input bit rst, input bit we, input logic [2:0] sel, input logic [7:0] d);
    logic [3:0] nib; logic blk; bit ok;
    if (rst) begin model_reset(); return; end
    m_echar = 0; m_etmo = 0;
    if (m_pend) begin
      for (int i = 0; i < 4; i++) m_com[i] = m_shad[i];
      m_cob = m_shb;
    end
    m_pend = 0;
    if (we && sel < 3'd4) begin
      ok = ref_conv(d, nib, blk);
      if (ok) begin m_shad[sel[1:0]] = nib; m_shb[sel[1:0]] = blk; end
      else m_echar = 1;
      m_staged = 1; m_quiet = 0;
    end else if (we && sel == 3'd4) begin
      m_staged = 0; m_pend = 1;
    end else if (m_staged) begin
      m_quiet++;
      if (m_quiet == TIMEOUT) begin
        for (int i = 0; i < 4; i++) m_shad[i] = m_com[i];
        m_shb = m_cob; m_staged = 0; m_etmo = 1;
      end
    end
    m_cyc++;
  endtask

  task automatic check_all();
    int idx;
    logic [15:0] e_dig;
    logic [3:0]  e_an, one_hot;
    idx     = (m_cyc / SCAN_DIV) % 4;
    one_hot = 4'b0001 << idx;
    e_an    = m_cob[idx] ? 4'b1111 : ~one_hot;
    e_dig   = {m_com[3], m_com[2], m_com[1], m_com[0]};
    chk("digits", {digit3, digit2, digit1, digit0}, e_dig);
    chk("blank", blank, m_cob);
    chk("an", an, e_an);
    chk("scan_nibble", scan_nibble, m_com[idx]);
    chk("busy", busy, m_staged);
    chk("err_char", err_char, m_echar);
    chk("err_timeout", err_timeout, m_etmo);
  endtask

  task automatic step(input bit we, input logic [2:0] sel, input logic [7:0] d, input bit rst = 1'b0);
    reset = rst; wr_en = we; select = sel; data = d;
    @(posedge clk);
    model_edge(rst, we, sel, d);
    #1;
    if (err_timeout) tmo_pulses++;
    if (err_char) char_pulses++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00);
  endtask

  logic [7:0] pool[10];

  initial begin
    pool = '{8'h30, 8'h35, 8'h39, 8'h41, 8'h46, 8'h43, 8'h20, 8'h47, 8'h2F, 8'h3A};
    model_reset();
    step(1'b0, 3'd0, 8'h00, 1'b1);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("rst_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    chk("rst_an", an, 4'b1110);
    chk("rst_scan", scan_nibble, 4'd1);
    chk("rst_busy", busy, 1'b0);
    idle(SCAN_DIV);
    chk("slot1_an", an, 4'b1101);
    chk("slot1_scan", scan_nibble, 4'd2);
    idle(3 * SCAN_DIV);

    step(1'b1, 3'd0, "9"); step(1'b1, 3'd1, "7");
    step(1'b1, 3'd2, "5"); step(1'b1, 3'd3, "3");
    chk("staged_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    chk("staged_busy", busy, 1'b1);
    step(1'b1, 3'd4, 8'h00);
    chk("commit_not_yet", {digit3, digit2, digit1, digit0}, 16'h4321);
    step(1'b0, 3'd0, 8'h00);
    chk("commit_digits", {digit3, digit2, digit1, digit0}, 16'h3579);
    chk("commit_busy", busy, 1'b0);

    char_pulses = 0;
    step(1'b1, 3'd1, "B"); step(1'b1, 3'd2, 8'h47);
    step(1'b1, 3'd4, 8'h00); idle(2);
    chk("hex_digit1", digit1, 4'hB);
    chk("bad_digit2", digit2, 4'd5);
    chk("err_char_count", char_pulses, 1);

    step(1'b1, 3'd3, " "); step(1'b1, 3'd4, 8'h00); idle(1);
    chk("space_blank", blank, 4'b1000);
    for (int i = 0; i < 8 * SCAN_DIV && ((m_cyc / SCAN_DIV) % 4) != 3; i++) idle(1);
    chk("slot3_reached", (m_cyc / SCAN_DIV) % 4, 3);
    chk("slot3_an_blank", an, 4'b1111);

    step(1'b0, 3'd0, 8'h00, 1'b1);
    tmo_pulses = 0;
    step(1'b1, 3'd0, "7");
    idle(TIMEOUT + 2);
    chk("tmo_count", tmo_pulses, 1);
    chk("tmo_busy", busy, 1'b0);
    step(1'b1, 3'd4, 8'h00); idle(2);
    chk("tmo_recommit", {digit3, digit2, digit1, digit0}, 16'h4321);

    step(1'b1, 3'd1, "E");
    chk("mid_busy", busy, 1'b1);
    tmo_pulses = 0; char_pulses = 0;
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("mid_rst_digits", {digit3, digit2, digit1, digit0}, 16'h4321);
    chk("mid_rst_busy", busy, 1'b0);
    step(1'b1, 3'd4, 8'h00); idle(TIMEOUT + 2);
    chk("mid_rst_after", {digit3, digit2, digit1, digit0}, 16'h4321);
    chk("mid_rst_pulses", tmo_pulses + char_pulses, 0);

    for (int i = 0; i < 4000; i++) begin
      int phase;
      bit we;
      phase = (i / 200) % 3;
      we = (phase == 0) ? ($urandom_range(0, 99) < 50) :
           (phase == 1) ? ($urandom_range(0, 99) < 10) :
                          ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 499) == 0)
        step(1'b0, 3'd0, 8'h00, 1'b1);
      else
        step(we, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 9) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
